alu_arbiter: RTL and testbench

- Shares the single sequential ALU (add/sub, Booth multiply, non-restoring divide; driven through its start/sel/finish interface) between two requesters.
- Round-robin arbitration; latches the winner's opcode and operands and holds them stable for the whole operation.
- Issues start, tracks the ALU's finish handshake, captures the result and returns it to the owner with a one-cycle done pulse.
- Watchdog aborts hung operations.

---
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one sequential ALU between two requesters
// Latches the winner's operands, runs the ALU start/finish handshake and returns the result with a watchdog.
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [1:0]          sel0,
  input  logic [1:0]          sel1,
  input  logic [DATA_W-1:0]   x0,
  input  logic [DATA_W-1:0]   y0,
  input  logic [DATA_W-1:0]   x1,
  input  logic [DATA_W-1:0]   y1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [2*DATA_W-1:0] res,
  output logic                err,
  output logic                busy,
  output logic                alu_start,
  output logic [1:0]          alu_sel,
  output logic [DATA_W-1:0]   alu_x,
  output logic [DATA_W-1:0]   alu_y,
  input  logic                alu_finish,
  input  logic [2*DATA_W-1:0] alu_res
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          last;
  logic          owner;
  logic          winner;
  logic          timed_out;

  // On a tie the requester that did not win last time gets the ALU.
  assign winner    = (req0 && req1) ? ~last : req1;
  assign timed_out = (timer == TIMER_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      last      <= 1'b1;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res       <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      alu_start <= 1'b0;
      alu_sel   <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner     <= winner;
            last      <= winner;
            alu_sel   <= winner ? sel1 : sel0;
            alu_x     <= winner ? x1 : x0;
            alu_y     <= winner ? y1 : y0;
            gnt0      <= ~winner;
            gnt1      <= winner;
            alu_start <= 1'b1;
            busy      <= 1'b1;
            timer     <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (timed_out) begin
            alu_start <= 1'b0;
            res       <= '0;
            err       <= 1'b1;
            done0     <= ~owner;
            done1     <= owner;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
            if (!alu_finish) begin
              alu_start <= 1'b0;
              state     <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          // The watchdog wins over a finish that rises in the same cycle.
          if (timed_out) begin
            res   <= '0;
            err   <= 1'b1;
            done0 <= ~owner;
            done1 <= owner;
            state <= RESP;
          end else if (alu_finish) begin
            res   <= alu_res;
            err   <= 1'b0;
            done0 <= ~owner;
            done1 <= owner;
            state <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
// Behavioural ALU, transaction scoreboard and round-robin model; table vectors plus random traffic.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int RW = 2 * W;
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic          req0, req1;
  logic [1:0]    sel0, sel1;
  logic [W-1:0]  x0, y0, x1, y1;
  logic          gnt0, gnt1, done0, done1;
  logic [RW-1:0] res;
  logic          err, busy, alu_start;
  logic [1:0]    alu_sel;
  logic [W-1:0]  alu_x, alu_y;
  logic          alu_finish;
  logic [RW-1:0] alu_res;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .sel0(sel0), .sel1(sel1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res(res), .err(err), .busy(busy), .alu_start(alu_start),
    .alu_sel(alu_sel), .alu_x(alu_x), .alu_y(alu_y),
    .alu_finish(alu_finish), .alu_res(alu_res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // ALU results: result packing for divide is {remainder, quotient}.
  function automatic logic [RW-1:0] alu_fn(input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [RW-1:0] r;
    case (s)
      2'b00:   r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      2'b01:   r = {{W{1'b0}}, a} - {{W{1'b0}}, b};
      2'b10:   r = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
      default: r = (b == '0) ? {a, {W{1'b1}}} : {a % b, a / b};
    endcase
    return r;
  endfunction

  // Behavioural sequential ALU: finish drops the cycle after start, rises alu_lat cycles later.
  logic          hang = 1'b0;
  logic          rand_lat = 1'b0;
  int            alu_lat = 5;
  int            cnt;
  logic [RW-1:0] pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_finish <= 1'b1;
      alu_res    <= '0;
      cnt        <= 0;
      pend       <= '0;
    end else if (alu_finish) begin
      if (alu_start) begin
        alu_finish <= 1'b0;
        cnt        <= rand_lat ? int'($urandom_range(1, 6)) : alu_lat;
        pend       <= alu_fn(alu_sel, alu_x, alu_y);
        alu_res    <= RW'($urandom);
      end
    end else if (!hang) begin
      if (cnt <= 1) begin
        alu_finish <= 1'b1;
        alu_res    <= pend;
      end else begin
        cnt     <= cnt - 1;
        alu_res <= RW'($urandom);
      end
    end
  end

  // What the arbiter saw at each rising edge.
  logic [1:0]   cap_req;
  logic [1:0]   cap_sel0, cap_sel1;
  logic [W-1:0] cap_x0, cap_y0, cap_x1, cap_y1;

  always @(posedge clk) begin
    cap_req  <= {req1, req0};
    cap_sel0 <= sel0;
    cap_sel1 <= sel1;
    cap_x0   <= x0;
    cap_y0   <= y0;
    cap_x1   <= x1;
    cap_y1   <= y1;
  end

  typedef struct packed {
    logic          e;
    logic [RW-1:0] r;
  } resp_t;

  resp_t                exp_q0[$];
  resp_t                exp_q1[$];
  int                   gnt_log[$];
  logic                 last_m = 1'b1;
  logic [2+2*W-1:0]     held = '0;
  logic                 mw;
  resp_t                mexp;

  always @(posedge rst) begin
    exp_q0.delete();
    exp_q1.delete();
    last_m = 1'b1;
    held   = '0;
  end

  // Scoreboard: round-robin winner, latched operands, result routing.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 | gnt1) begin
        mw = (cap_req == 2'b11) ? ~last_m : cap_req[1];
        chk("grant_had_request", cap_req != 2'b00, 1);
        chk("grant_winner", {gnt1, gnt0}, mw ? 2'b10 : 2'b01);
        chk("grant_not_with_done", {done1, done0}, 2'b00);
        last_m = mw;
        gnt_log.push_back(int'(gnt1));
        held = mw ? {cap_sel1, cap_x1, cap_y1} : {cap_sel0, cap_x0, cap_y0};
        mexp = hang ? resp_t'({1'b1, {RW{1'b0}}})
                    : resp_t'({1'b0, (mw ? alu_fn(cap_sel1, cap_x1, cap_y1) : alu_fn(cap_sel0, cap_x0, cap_y0))});
        if (mw) exp_q1.push_back(mexp);
        else    exp_q0.push_back(mexp);
        chk("latched_operands", {alu_sel, alu_x, alu_y}, held);
      end else begin
        chk("held_operands", {alu_sel, alu_x, alu_y}, held);
      end
      if (done0 | done1) begin
        chk("done_onehot", {done1, done0} == 2'b11, 0);
        chk("busy_at_done", busy, 1);
        if (done0) begin
          chk("done0_expected", exp_q0.size() != 0, 1);
          if (exp_q0.size() != 0) begin
            mexp = exp_q0.pop_front();
            chk("resp0", {err, res}, mexp);
          end
        end
        if (done1) begin
          chk("done1_expected", exp_q1.size() != 0, 1);
          if (exp_q1.size() != 0) begin
            mexp = exp_q1.pop_front();
            chk("resp1", {err, res}, mexp);
          end
        end
      end
    end
  end

  task automatic drive(input int who, input logic r, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (who == 0) begin
      req0 = r; sel0 = s; x0 = a; y0 = b;
    end else begin
      req1 = r; sel1 = s; x1 = a; y1 = b;
    end
  endtask

  task automatic set_req(input int who, input logic r);
    if (who == 0) req0 = r;
    else          req1 = r;
  endtask

  task automatic wait_done(input int who, input int start, output int lat, output logic [RW-1:0] r, output logic e);
    lat = start;
    while (!(who == 0 ? done0 : done1) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("done_within_bound", (who == 0) ? done0 : done1, 1);
    chk("start_low_at_done", alu_start, 0);
    r = res;
    e = err;
  endtask

  // Single-requester op issued from an IDLE negedge; returns after the following IDLE cycle.
  task automatic do_op(input int who, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [RW-1:0] r, output logic e, output int lat);
    drive(who, 1'b1, s, a, b);
    @(negedge clk);
    chk("gnt_next_cycle", (who == 0) ? gnt0 : gnt1, 1);
    chk("start_with_gnt", {busy, alu_start}, 2'b11);
    set_req(who, 1'b0);
    @(negedge clk);
    chk("start_held_while_finish_high", alu_start, 1);
    @(negedge clk);
    chk("start_dropped_after_finish_low", alu_start, 0);
    wait_done(who, 2, lat, r, e);
    @(negedge clk);
  endtask

  task automatic client(input int who, input int n, input bit rnd, input logic [1:0] s,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic [RW-1:0] want);
    logic [RW-1:0] r;
    logic          e;
    int            lat;
    int            k;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        drive(who, 1'b1, 2'($urandom), W'($urandom), W'($urandom));
      end else begin
        drive(who, 1'b1, s, a, b);
      end
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!((who == 0) ? gnt0 : gnt1) && k < 300);
      chk("client_gnt_bound", (who == 0) ? gnt0 : gnt1, 1);
      set_req(who, 1'b0);
      wait_done(who, 0, lat, r, e);
      if (!rnd) chk("rr_result", {e, r}, {1'b0, want});
    end
  endtask

  typedef struct {
    int            who;
    logic [1:0]    s;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    int            lat;
    logic [RW-1:0] want;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [RW-1:0] r;
    logic          e;
    int            lat;
    int            k;

    vt[0] = '{0, 2'b00, 8'd25,  8'd17, 5, 16'd42};
    vt[1] = '{1, 2'b01, 8'd10,  8'd20, 2, 16'hFFF6};
    vt[2] = '{0, 2'b10, 8'd7,   8'd6,  3, 16'd42};
    vt[3] = '{1, 2'b10, 8'hFD,  8'd5,  1, 16'hFFF1};
    vt[4] = '{0, 2'b11, 8'd100, 8'd7,  6, 16'h020E};
    vt[5] = '{1, 2'b00, 8'hFF,  8'hFF, 8, 16'h01FE};

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    sel0 = '0; sel1 = '0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {gnt0, gnt1, done0, done1, res, err, busy, alu_start, alu_sel, alu_x, alu_y}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {gnt0, gnt1, done0, done1, res, err, busy, alu_start, alu_sel, alu_x, alu_y}, '0);

    // First tie after reset goes to requester 0.
    drive(0, 1'b1, 2'b00, 8'd1, 8'd2);
    drive(1, 1'b1, 2'b00, 8'd3, 8'd4);
    @(negedge clk);
    chk("first_tie_gnt", {gnt1, gnt0}, 2'b01);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    wait_done(0, 0, lat, r, e);
    chk("first_tie_res", {e, r}, {1'b0, 16'd3});
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      alu_lat = vt[i].lat;
      do_op(vt[i].who, vt[i].s, vt[i].a, vt[i].b, r, e, lat);
      chk("vec_result", {e, r}, {1'b0, vt[i].want});
      chk("vec_latency", lat, vt[i].lat + 2);
    end

    // Watchdog: ALU never raises finish.
    hang = 1'b1;
    do_op(1, 2'b10, 8'd3, 8'd4, r, e, lat);
    chk("timeout_latency", lat, TO);
    chk("timeout_resp", {e, r}, {1'b1, 16'd0});
    chk("timeout_back_idle", busy, 0);
    hang = 1'b0;
    k = 0;
    while (!alu_finish && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("alu_recovered", alu_finish, 1);

    // Round-robin with both requesters kept busy.
    alu_lat = 3;
    gnt_log.delete();
    fork
      client(0, 2, 1'b0, 2'b10, 8'd7, 8'd6, 16'd42);
      client(1, 2, 1'b0, 2'b11, 8'd100, 8'd7, 16'h020E);
    join
    chk("rr_grant_count", gnt_log.size(), 4);
    for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("rr_order", gnt_log[i], i % 2);
    @(negedge clk);
    @(negedge clk);

    // Operand changes after the grant must not reach the ALU.
    alu_lat = 6;
    fork
      do_op(0, 2'b11, 8'd200, 8'd9, r, e, lat);
      begin
        repeat (2) @(negedge clk);
        repeat (6) begin
          @(negedge clk);
          #1;
          sel0 = 2'($urandom);
          x0   = W'($urandom);
          y0   = W'($urandom);
        end
      end
    join
    chk("stable_div_result", {e, r}, {1'b0, 16'h0216});
    chk("stable_alu_bus", {alu_sel, alu_x, alu_y}, {2'b11, 8'd200, 8'd9});

    // Reset in the middle of a multiply.
    alu_lat = 8;
    drive(0, 1'b1, 2'b10, 8'd7, 8'd6);
    @(negedge clk);
    chk("midop_gnt", gnt0, 1);
    set_req(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midop_in_wait_done", {busy, alu_start}, 2'b10);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {gnt0, gnt1, done0, done1, res, err, busy, alu_start, alu_sel, alu_x, alu_y}, '0);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 | done1) k++;
    end
    chk("no_done_after_reset", k, 0);
    alu_lat = 2;
    do_op(1, 2'b00, 8'd1, 8'd2, r, e, lat);
    chk("post_reset_result", {e, r}, {1'b0, 16'd3});

    // Random traffic from both requesters with random ALU latency.
    rand_lat = 1'b1;
    fork
      client(0, 20, 1'b1, 2'b00, '0, '0, '0);
      client(1, 20, 1'b1, 2'b00, '0, '0, '0);
    join
    repeat (4) @(negedge clk);
    chk("random_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
